// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the regfile write port between N_REQ writeback sources; define RF_WR_ARB_RR_EN for round-robin instead of fixed priority with starvation guard
module rf_wr_arbiter #(
  parameter int N_REQ      = 3,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_LIM = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     arb_stall
);
  logic [N_REQ-1:0]  live, x0, gnt;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  int                n_live;

  // split requests into live writes and x0 writes (accepted and dropped), count live ones
  always_comb begin
    live   = '0;
    x0     = '0;
    n_live = 0;
    for (int i = 0; i < N_REQ; i++) begin
      live[i] = req_valid[i] && (|req_addr[i*ADDR_W +: ADDR_W]);
      x0[i]   = req_valid[i] && ~(|req_addr[i*ADDR_W +: ADDR_W]);
      n_live  = n_live + int'(live[i]);
    end
  end

`ifdef RF_WR_ARB_RR_EN
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [IW-1:0] ptr, g_idx;

  // round-robin search starting at ptr, wrapping modulo N_REQ
  always_comb begin
    gnt   = '0;
    g_idx = '0;
    for (int k = 0; k < N_REQ; k++)
      if (~(|gnt) && live[(int'(ptr) + k) % N_REQ]) begin
        gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
        g_idx = IW'((int'(ptr) + k) % N_REQ);
      end
  end

  // pointer moves past the winner; x0 accepts never touch it
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (|gnt) ptr <= (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + IW'(1);
`else
  logic [3:0]       cnt [N_REQ];
  logic [N_REQ-1:0] starved, cand;

  // starved live requesters pre-empt everyone; lowest index of the candidate set wins
  always_comb begin
    starved = '0;
    for (int i = 1; i < N_REQ; i++) starved[i] = live[i] && (cnt[i] == 4'(STARVE_LIM));
    cand = (|starved) ? starved : live;
    gnt  = cand & (~cand + N_REQ'(1));
  end

  // per-requester wait counters, saturating at the starvation limit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= (i != 0 && live[i] && !gnt[i]) ?
                  ((cnt[i] == 4'(STARVE_LIM)) ? cnt[i] : cnt[i] + 4'd1) : 4'd0;
    end
`endif

  // select the winner's address and data
  always_comb begin
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) begin
        g_addr = req_addr[i*ADDR_W +: ADDR_W];
        g_data = req_data[i*DATA_W +: DATA_W];
      end
  end

  assign req_ready = rst ? '0 : (gnt | x0);

  // registered write port and stall flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      arb_stall <= 1'b0;
    end else begin
      wr_en     <= |gnt;
      arb_stall <= n_live > 1;
      if (|gnt) begin
        wr_addr <= g_addr;
        wr_data <= g_data;
      end
    end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed self-checking bench for rf_wr_arbiter
module tb_rf_wr_arbiter;
  localparam int N = 3, AW = 5, DW = 32;
  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            arb_stall;
  int              n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .arb_stall(arb_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clr;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  initial begin
    logic [N-1:0] seq [];
    logic [AW-1:0] adr;
    rst = 1'b1;
    clr();
    set_req(0, 1'b1, 5'd0, 32'h1);
    set_req(1, 1'b1, 5'd3, 32'h2);
    #1;
    check("rst_ready", req_ready, 3'b000);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_stall", arb_stall, 0);
    clr();
    tick();
    tick();
    rst = 1'b0;

    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("single_ready", req_ready, 3'b010);
    tick();
    clr();
    check("single_wr_en", wr_en, 1);
    check("single_wr_addr", wr_addr, 5);
    check("single_wr_data", wr_data, 32'hDEADBEEF);
    check("single_stall", arb_stall, 0);
    tick();
    check("single_wr_en_off", wr_en, 0);
    check("single_addr_hold", wr_addr, 5);

    set_req(0, 1'b1, 5'd0, 32'h1111);
    set_req(2, 1'b1, 5'd7, 32'h2222);
    #1;
    check("x0_ready", req_ready, 3'b101);
    tick();
    clr();
    check("x0_wr_en", wr_en, 1);
    check("x0_wr_addr", wr_addr, 7);
    check("x0_wr_data", wr_data, 32'h2222);
    check("x0_stall", arb_stall, 0);
    tick();

`ifndef RF_WR_ARB_RR_EN
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    set_req(0, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 5'd2, 32'hB);
    for (int k = 0; k < seq.size(); k++) begin
      #1;
      check($sformatf("starve_ready_%0d", k), req_ready, seq[k]);
      tick();
      adr = seq[k][0] ? 5'd1 : 5'd2;
      check($sformatf("starve_addr_%0d", k), wr_addr, adr);
      check($sformatf("starve_stall_%0d", k), arb_stall, 1);
    end
    clr();
    tick();

    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b001};
    set_req(0, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 5'd2, 32'hB);
    set_req(2, 1'b1, 5'd3, 32'hC);
    for (int k = 0; k < seq.size(); k++) begin
      #1;
      check($sformatf("simul_ready_%0d", k), req_ready, seq[k]);
      tick();
    end
    clr();
    tick();

    set_req(0, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 5'd2, 32'hB);
    tick();
    tick();
    check("pre_rst_wr_en", wr_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_ready", req_ready, 3'b000);
    check("mid_rst_wr_addr", wr_addr, 0);
    tick();
    rst = 1'b0;
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    for (int k = 0; k < seq.size(); k++) begin
      #1;
      check($sformatf("post_rst_ready_%0d", k), req_ready, seq[k]);
      tick();
    end
    check("post_rst_wr_addr", wr_addr, 2);
    clr();
    tick();
`else
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    set_req(0, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 5'd2, 32'hB);
    set_req(2, 1'b1, 5'd3, 32'hC);
    for (int k = 0; k < seq.size(); k++) begin
      #1;
      check($sformatf("rr_ready_%0d", k), req_ready, seq[k]);
      tick();
      check($sformatf("rr_stall_%0d", k), arb_stall, 1);
    end
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
    for (int k = 0; k < seq.size(); k++) begin
      if (k == 2) set_req(1, 1'b0, 5'd0, 32'h0);
      #1;
      check($sformatf("rr_drop_ready_%0d", k), req_ready, seq[k]);
      tick();
    end
    clr();
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
